rv32i_mc_control_unit: RTL
==========================

# rv32i_mc_control_unit

Multi-cycle control unit for the RV32I core: the instruction-side driver of the ALU's `ALU_Controls` and consumer of its `taken` flag. It captures the fetched instruction, sequences FETCH/DECODE/EXECUTE/MEM/WB, and issues ALU opcodes, operand selects, register-file, memory and PC enables. It replaces the single-cycle decoder and adds a data-memory ready handshake.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_code` in 32: instruction-memory read data, valid during FETCH.
- `taken` in 1: ALU branch-compare result, combinational.
- `mem_ready` in 1: data memory has completed the current access.
- `ALU_Controls` out 4: ALU operation code.
- `alu_src_a` out 1: 0 = rs1, 1 = PC.
- `alu_src_b` out 1: 0 = rs2, 1 = immediate.
- `imm_sel` out 3: immediate format, encoded as 0 I, 1 S, 2 B, 3 U, 4 J.
- `rf_wd_sel` out 3: write-data source, encoded as 0 ALU, 1 mem, 2 imm (LUI), 3 PC+imm (AUIPC), 4 PC+4.
- `reg_wr_en` out 1: register-file write strobe.
- `mem_rd_en` / `mem_wr_en` out 1 each: data-memory strobes.
- `pc_sel` out 2: next-PC source, encoded as 0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1.
- `pc_en` out 1: PC update strobe.
- `illegal_instr` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- Internal 32-bit IR is loaded from `instr_code` on the FETCH clock edge. All decode is taken from IR, never from `instr_code`.
- ALU codes are fixed: ADD 0, SUB 1, SLL 2, SRL 3, SRA 4, SLT 5, SLTU 6, XOR 7, OR 8, AND 9.
- R-type decode by {funct7[5], funct3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0101 SRL, 1101 SRA
  - 0010 SLT, 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND
  - Any other combination is illegal.
- I-ALU decode: same table, but funct7[5] is honoured only for funct3=101 (SRAI). ADDI never maps to SUB.
- Loads, stores, JALR, AUIPC and JAL drive ADD.
- Branches drive `ALU_Controls` = {1'b0, funct3}. funct3 of 010 and 011 is illegal.
- FSM states: FETCH → DECODE → EXECUTE, then:
  - EXECUTE → FETCH for R, I-ALU, LUI, AUIPC, JAL, JALR and B.
  - EXECUTE → MEM for loads and stores.
  - MEM stays in MEM while `mem_ready`=0.
  - MEM → FETCH for stores.
  - MEM → WB for loads; WB → FETCH.
- EXECUTE completion for the non-memory classes:
  - `reg_wr_en`=1 except for B.
  - `pc_en`=1.
  - `pc_sel`: 2 for JALR, 1 for JAL, `taken`?1:0 for B, 0 otherwise.
- MEM: the store or load strobe is held high for every cycle the FSM remains in MEM.
- Load WB: `reg_wr_en`=1, `rf_wd_sel`=1, `pc_en`=1.
- Store completion: `pc_en`=1 in the MEM cycle where `mem_ready`=1.
- Illegal opcode or funct:
  - DECODE → FETCH directly.
  - `illegal_instr` pulses for that DECODE cycle.
  - `pc_en`=1 with `pc_sel`=0, so the instruction is skipped as a NOP.
  - No register or memory write occurs.
- Select outputs (`ALU_Controls`, `alu_src_*`, `imm_sel`, `rf_wd_sel`) are decoded from IR in every state so operands are stable before their strobe.
- Strobes are asserted only in the states listed above. `pc_en` is asserted exactly once per instruction.

## Timing
- Cycles per instruction:
  - R, I, LUI, AUIPC, JAL, JALR, B: 3
  - Store: 4 + wait cycles
  - Load: 5 + wait cycles
- All outputs are Moore functions of state and IR. The exceptions are `pc_sel` in B-EXECUTE, which follows `taken` combinationally, and the MEM exit, which depends on `mem_ready`.
- Reset (asynchronous):
  - State goes to FETCH; IR goes to 0x00000013 (NOP).
  - All strobes and `illegal_instr` are 0; `ALU_Controls`=0 and all selects are 0.
- Reset asserted mid-instruction, including during a MEM wait: no strobe may appear in the cycle of reset or after it. Execution restarts at FETCH.
- `mem_ready` already high on the first MEM cycle: single-cycle MEM, no extra wait.

## Test plan
- add x3,x1,x2 (0x002081B3):
  - `ALU_Controls`=0, `alu_src_b`=0.
  - `reg_wr_en` and `pc_en` high only in cycle 3; 3 cycles total.
- sub 0x402081B3 → `ALU_Controls`=1.
- srai x5,x6,3 (0x40335293) → `ALU_Controls`=4, `alu_src_b`=1, `imm_sel`=0.
- beq x1,x2,+8 (0x00208463):
  - `ALU_Controls`=0 and `reg_wr_en`=0.
  - `taken`=1 gives `pc_sel`=1; `taken`=0 gives `pc_sel`=0.
- lw x4,0(x1) (0x0000A203) with `mem_ready` low for 2 cycles:
  - `mem_rd_en` high for 3 cycles.
  - WB has `rf_wd_sel`=1; 7 cycles total.
- Illegal opcode 0x0000007F, then reset asserted during a store's MEM wait:
  - `illegal_instr` pulses once and no writes occur.
  - After reset, `mem_wr_en`=0 immediately and the state is FETCH.

Source files
------------

// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle RV32I control unit: captures the instruction into IR, sequences
// FETCH/DECODE/EXECUTE/MEM/WB and issues ALU codes, selects and strobes.
module rv32i_mc_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_code,
  input  logic        taken,
  input  logic        mem_ready,
  output logic [3:0]  ALU_Controls,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [2:0]  imm_sel,
  output logic [2:0]  rf_wd_sel,
  output logic        reg_wr_en,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [1:0]  pc_sel,
  output logic        pc_en,
  output logic        illegal_instr
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SRL = 4'd3,
                         ALU_SRA = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_XOR = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                         OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                         OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam logic [2:0] WD_ALU = 3'd0, WD_MEM = 3'd1, WD_IMM = 3'd2, WD_PCIMM = 3'd3,
                         WD_PC4 = 3'd4;
  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_ir;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign f7b5      = ir_q[30];
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic       is_load, is_store, is_branch, is_jal, is_jalr, legal;
  logic [3:0] dec_alu;
  logic       dec_src_a, dec_src_b;
  logic [2:0] dec_imm, dec_wd;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    legal     = 1'b1;
    dec_alu   = ALU_ADD;
    dec_src_a = 1'b0;
    dec_src_b = 1'b0;
    dec_imm   = IMM_I;
    dec_wd    = WD_ALU;
    case (opcode)
      OP_R: begin
        dec_alu = alu_from_funct(funct3, f7b5);
        if (f7b5 && funct3 != 3'b000 && funct3 != 3'b101) legal = 1'b0;
      end
      OP_I: begin
        // funct7[5] only distinguishes SRAI from SRLI; ADDI never becomes SUB
        dec_alu   = alu_from_funct(funct3, f7b5 && funct3 == 3'b101);
        dec_src_b = 1'b1;
      end
      OP_LOAD: begin
        is_load   = 1'b1;
        dec_src_b = 1'b1;
        dec_wd    = WD_MEM;
      end
      OP_STORE: begin
        is_store  = 1'b1;
        dec_src_b = 1'b1;
        dec_imm   = IMM_S;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        dec_alu   = {1'b0, funct3};
        dec_imm   = IMM_B;
        if (funct3[2:1] == 2'b01) legal = 1'b0;
      end
      OP_JAL: begin
        is_jal    = 1'b1;
        dec_src_a = 1'b1;
        dec_src_b = 1'b1;
        dec_imm   = IMM_J;
        dec_wd    = WD_PC4;
      end
      OP_JALR: begin
        is_jalr   = 1'b1;
        dec_src_b = 1'b1;
        dec_wd    = WD_PC4;
      end
      OP_LUI: begin
        dec_src_b = 1'b1;
        dec_imm   = IMM_U;
        dec_wd    = WD_IMM;
      end
      OP_AUIPC: begin
        dec_src_a = 1'b1;
        dec_src_b = 1'b1;
        dec_imm   = IMM_U;
        dec_wd    = WD_PCIMM;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_alu   = ALU_ADD;
      dec_src_a = 1'b0;
      dec_src_b = 1'b0;
      dec_imm   = IMM_I;
      dec_wd    = WD_ALU;
    end
  end

  logic       rw_c, rd_c, wr_c, pe_c, il_c;
  logic [1:0] ps_c;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rw_c    = 1'b0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    pe_c    = 1'b0;
    il_c    = 1'b0;
    ps_c    = 2'd0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr_code;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          il_c    = 1'b1;
          pe_c    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          rw_c    = !is_branch;
          pe_c    = 1'b1;
          if (is_jalr)        ps_c = 2'd2;
          else if (is_jal)    ps_c = 2'd1;
          else if (is_branch) ps_c = {1'b0, taken};
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        rd_c = is_load;
        wr_c = is_store;
        pe_c = is_store && mem_ready;
        if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
      end
      S_WB: begin
        rw_c    = 1'b1;
        pe_c    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= IR_NOP;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs are forced quiet while reset is held so nothing escapes mid-instruction
  assign ALU_Controls  = reset ? 4'd0 : dec_alu;
  assign alu_src_a     = !reset && dec_src_a;
  assign alu_src_b     = !reset && dec_src_b;
  assign imm_sel       = reset ? 3'd0 : dec_imm;
  assign rf_wd_sel     = reset ? 3'd0 : dec_wd;
  assign reg_wr_en     = !reset && rw_c;
  assign mem_rd_en     = !reset && rd_c;
  assign mem_wr_en     = !reset && wr_c;
  assign pc_en         = !reset && pe_c;
  assign pc_sel        = reset ? 2'd0 : ps_c;
  assign illegal_instr = !reset && il_c;

endmodule
